// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared control bundle, ALU opcodes, bubble word and FSM states
//               for the decode-to-execute stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_write;
        logic       read_en;
        logic [1:0] wb_sel;
        logic       write_en;
        logic [1:0] br_type;
        logic       sel_A;
        logic       sel_B;
    } ctrl_t;

    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_and   = 4'b0010;
    localparam logic [3:0] c_alu_or    = 4'b0011;
    localparam logic [3:0] c_alu_xor   = 4'b0100;
    localparam logic [3:0] c_alu_sll   = 4'b0101;
    localparam logic [3:0] c_alu_srl   = 4'b0110;
    localparam logic [3:0] c_alu_sra   = 4'b0111;
    localparam logic [3:0] c_alu_slt   = 4'b1000;
    localparam logic [3:0] c_alu_sltu  = 4'b1001;
    localparam logic [3:0] c_alu_lui   = 4'b1010;
    localparam logic [3:0] c_alu_undef = 4'b1111;

    // A bubble must be side-effect free: no writes, no branch, undefined ALU op.
    localparam ctrl_t c_bubble = '{alu_op: c_alu_undef, default: '0};

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_LDSTALL = 2'b01,
        S_FLUSH   = 2'b10
    } state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use and taken-redirect detection.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_read_en,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_br_taken,
    output logic       o_load_use,
    output logic       o_redirect
);

    logic w_src_match;

    assign w_src_match = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);

    // x0 is hard-wired zero, so a load targeting it never forwards data.
    assign o_load_use = i_ex_valid & i_ex_read_en & (i_ex_rd != 5'd0)
                      & i_id_valid & w_src_match;

    assign o_redirect = i_ex_valid & i_br_taken;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_reg
// Description : Decode-to-execute control register with load-use stall and
//               taken-branch flush sequencing. Optional event counters are
//               built when PIPE_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_reg
    import pipe_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              br_taken,
    output ctrl_t             ex_ctrl,
    output logic [4:0]        ex_rd,
    output logic              ex_valid,
    output logic              pc_hold,
    output logic              if_flush
`ifdef PIPE_PERF_EN
   ,output logic [PERF_W-1:0] perf_retired,
    output logic [PERF_W-1:0] perf_bubbles
`endif
);

    state_e     r_state;
    state_e     w_next_state;
    ctrl_t      r_ex_ctrl;
    logic [4:0] r_ex_rd;
    logic       r_ex_valid;
    logic       w_load_use;
    logic       w_redirect;
    logic       w_bubble;
    logic       w_pc_hold;
    logic       w_if_flush;

    hazard_detect u_hazard_detect (
        .i_ex_valid   (r_ex_valid),
        .i_ex_read_en (r_ex_ctrl.read_en),
        .i_ex_rd      (r_ex_rd),
        .i_id_valid   (id_valid),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_br_taken   (br_taken),
        .o_load_use   (w_load_use),
        .o_redirect   (w_redirect)
    );

    always_comb begin
        w_next_state = S_RUN;
        w_bubble     = ~id_valid;
        w_pc_hold    = 1'b0;
        w_if_flush   = 1'b0;
        case (r_state)
            S_RUN, S_FLUSH: begin
                // Redirect outranks the stall: the held instruction is squashed anyway.
                if (w_redirect) begin
                    w_if_flush   = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = S_FLUSH;
                end else if (w_load_use) begin
                    w_pc_hold    = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = S_LDSTALL;
                end
            end
            S_LDSTALL: begin
                w_next_state = S_RUN;
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    assign pc_hold  = w_pc_hold  & ~rst;
    assign if_flush = w_if_flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_ex_ctrl  <= c_bubble;
            r_ex_rd    <= 5'd0;
            r_ex_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_bubble) begin
                r_ex_ctrl  <= c_bubble;
                r_ex_rd    <= 5'd0;
                r_ex_valid <= 1'b0;
            end else begin
                r_ex_ctrl  <= id_ctrl;
                r_ex_rd    <= id_rd;
                r_ex_valid <= 1'b1;
            end
        end
    end

    assign ex_ctrl  = r_ex_ctrl;
    assign ex_rd    = r_ex_rd;
    assign ex_valid = r_ex_valid;

`ifdef PIPE_PERF_EN
    logic [PERF_W-1:0] r_perf_retired;
    logic [PERF_W-1:0] r_perf_bubbles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (r_ex_valid) begin
                r_perf_retired <= r_perf_retired + PERF_W'(1);
            end
            if (w_bubble) begin
                r_perf_bubbles <= r_perf_bubbles + PERF_W'(1);
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_bubbles = r_perf_bubbles;
`else
    // Counters are absent; the width parameter is kept for a uniform interface.
    if (PERF_W < 1) begin : g_perf_w_unused
    end
`endif

endmodule : pipe_ctrl_reg
`default_nettype wire
